press_classifier: RTL



---
 rtl/press_classifier_if.sv | 21 ++
 rtl/press_classifier.sv | 100 ++++++++++
 2 files changed

// File: rtl/press_classifier_if.sv
// Button-gesture port bundle: debounced level and timebase in, event pulses and status out.
// The classifier (slave) samples db/m_tick every clk; the pulse outputs are single-cycle events with no back-pressure.
interface press_classifier_if;
  logic       db;
  logic       m_tick;
  logic       short_press;
  logic       long_press;
  logic       double_press;
  logic       busy;
  logic [2:0] state_dbg;

  modport master (
    output db, m_tick,
    input  short_press, long_press, double_press, busy, state_dbg
  );

  modport slave (
    input  db, m_tick,
    output short_press, long_press, double_press, busy, state_dbg
  );
endinterface

// File: rtl/press_classifier.sv
// Classifies debounced button gestures into short, long and double presses.
// Timing is counted in m_tick periods by a single counter shared by all timed states.
module press_classifier #(
  parameter int LONG_TICKS = 100,
  parameter int DBL_TICKS  = 30
) (
  input logic               clk,
  input logic               reset,
  press_classifier_if.slave bus
);

  localparam int MAX_TICKS = (LONG_TICKS > DBL_TICKS) ? LONG_TICKS : DBL_TICKS;
  localparam int TW        = $clog2(MAX_TICKS + 1);
  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_TICKS - 1);
  localparam logic [TW-1:0] DBL_LAST  = TW'(DBL_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESSED1  = 3'd1,
    S_LONG_HOLD = 3'd2,
    S_RELEASED1 = 3'd3,
    S_PRESSED2  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          double_q, double_d;
  logic          busy_q, busy_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tcnt_q   <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      busy_q   <= busy_d;
    end
  end

  // Level changes take priority over the terminal tick in every timed state.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.db) state_d = S_PRESSED1;
      end
      S_PRESSED1: begin
        if (!bus.db)                             state_d = S_RELEASED1;
        else if (bus.m_tick && tcnt_q == LONG_LAST) state_d = S_LONG_HOLD;
        else if (bus.m_tick)                     tcnt_d  = tcnt_q + TW'(1);
      end
      S_LONG_HOLD: begin
        if (!bus.db) state_d = S_IDLE;
      end
      S_RELEASED1: begin
        if (bus.db)                              state_d = S_PRESSED2;
        else if (bus.m_tick && tcnt_q == DBL_LAST) state_d = S_IDLE;
        else if (bus.m_tick)                     tcnt_d  = tcnt_q + TW'(1);
      end
      S_PRESSED2: begin
        if (!bus.db) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) tcnt_d = '0;
  end

  always_comb begin
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    busy_d   = (state_d != S_IDLE);
    case (state_q)
      S_PRESSED1:  long_d   = bus.db && bus.m_tick && (tcnt_q == LONG_LAST);
      S_RELEASED1: begin
        double_d = bus.db;
        short_d  = !bus.db && bus.m_tick && (tcnt_q == DBL_LAST);
      end
      default: ;
    endcase
  end

  assign bus.short_press  = short_q;
  assign bus.long_press   = long_q;
  assign bus.double_press = double_q;
  assign bus.busy         = busy_q;
  assign bus.state_dbg    = state_q;

endmodule
